// File: rtl/note_player_pkg.sv
// rtl/note_player_pkg.sv - shared state encoding for the note player
package note_player_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    LOAD_HIGH = 3'b001,
    WAIT_HIGH = 3'b010,
    LOAD_LOW  = 3'b011,
    WAIT_LOW  = 3'b100,
    DONE      = 3'b101
  } state_t;

endpackage

// File: rtl/note_player_pwm_if.sv
// rtl/note_player_pwm_if.sv - control/status bundle between a host and the note player
interface note_player_pwm_if #(
  parameter int NBITS = 16,
  parameter int DBITS = 16
);
  logic             start;
  logic             stop;
  logic [NBITS-1:0] high_half;
  logic [NBITS-1:0] low_half;
  logic [DBITS-1:0] duration;
  logic             note;
  logic             count_load;
  logic             busy;
  logic             done;
  logic [2:0]       state;

  modport master (
    output start, stop, high_half, low_half, duration,
    input  note, count_load, busy, done, state
  );

  modport slave (
    input  start, stop, high_half, low_half, duration,
    output note, count_load, busy, done, state
  );
endinterface

// File: rtl/note_down_counter.sv
// rtl/note_down_counter.sv - loadable down counter that saturates at zero
module note_down_counter #(
  parameter int NBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [NBITS-1:0] load_value,
  output logic [NBITS-1:0] count,
  output logic             is_zero
);

  assign is_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !is_zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/note_player_pwm.sv
// rtl/note_player_pwm.sv - square-wave note generator: H+2 high, L+2 low, D periods (0 = endless)
module note_player_pwm
  import note_player_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int DBITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  note_player_pwm_if.slave   bus
);

  state_t           state_q;
  state_t           state_d;
  logic [NBITS-1:0] high_q;
  logic [NBITS-1:0] low_q;
  logic [NBITS-1:0] phase_count;
  logic             phase_zero;
  logic [DBITS-1:0] period_count;
  logic             period_zero;
  logic             accept;
  logic             end_of_period;
  logic             period_last;

  assign accept        = (state_q == IDLE) && bus.start && !bus.stop;
  assign end_of_period = (state_q == WAIT_LOW) && phase_zero;
  assign period_last   = (period_count == DBITS'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      high_q <= '0;
      low_q  <= '0;
    end else if (accept) begin
      high_q <= bus.high_half;
      low_q  <= bus.low_half;
    end
  end

  note_down_counter #(.NBITS(NBITS)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .load       ((state_q == LOAD_HIGH) || (state_q == LOAD_LOW)),
    .dec        ((state_q == WAIT_HIGH) || (state_q == WAIT_LOW)),
    .load_value ((state_q == LOAD_HIGH) ? high_q : low_q),
    .count      (phase_count),
    .is_zero    (phase_zero)
  );

  // Period counter doubles as the latched duration; zero means play forever.
  note_down_counter #(.NBITS(DBITS)) u_period (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .dec        (end_of_period && !period_zero && !period_last && !bus.stop),
    .load_value (bus.duration),
    .count      (period_count),
    .is_zero    (period_zero)
  );

  always_comb begin
    state_d = state_q;
    if (bus.stop && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (accept) state_d = LOAD_HIGH;
        LOAD_HIGH: state_d = WAIT_HIGH;
        WAIT_HIGH: if (phase_zero) state_d = LOAD_LOW;
        LOAD_LOW:  state_d = WAIT_LOW;
        WAIT_LOW:  if (phase_zero) state_d = (!period_zero && period_last) ? DONE : LOAD_HIGH;
        DONE:      state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    bus.note       = (state_q == LOAD_HIGH) || (state_q == WAIT_HIGH);
    bus.count_load = (state_q == LOAD_HIGH) || (state_q == LOAD_LOW);
    bus.busy       = (state_q != IDLE);
    bus.done       = (state_q == DONE);
    bus.state      = state_q;
  end

endmodule

// File: tb/tb_note_player_pwm.sv
// tb/tb_note_player_pwm.sv - directed checks on a 16-bit and a 4-bit note player
module tb_note_player_pwm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  note_player_pwm_if #(.NBITS(16), .DBITS(16)) bus_a ();
  note_player_pwm_if #(.NBITS(4),  .DBITS(4))  bus_b ();

  note_player_pwm #(.NBITS(16), .DBITS(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  note_player_pwm #(.NBITS(4),  .DBITS(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic [15:0] h,
                       input logic [15:0] l, input logic [15:0] d);
    bus_a.start = st; bus_a.stop = sp;
    bus_a.high_half = h; bus_a.low_half = l; bus_a.duration = d;
    bus_b.start = st; bus_b.stop = sp;
    bus_b.high_half = h[3:0]; bus_b.low_half = l[3:0]; bus_b.duration = d[3:0];
  endtask

  // {note, count_load, busy, done, state}
  function automatic logic [6:0] obs_a();
    return {bus_a.note, bus_a.count_load, bus_a.busy, bus_a.done, bus_a.state};
  endfunction
  function automatic logic [6:0] obs_b();
    return {bus_b.note, bus_b.count_load, bus_b.busy, bus_b.done, bus_b.state};
  endfunction

  task automatic check_both(input string tag, input logic [6:0] exp);
    check({tag, "_a"}, 32'(obs_a()), 32'(exp));
    check({tag, "_b"}, 32'(obs_b()), 32'(exp));
  endtask

  // Expected outputs k cycles after the start cycle of a note.
  function automatic logic [6:0] model(input int k, input int h, input int l, input int d);
    int p, last, o;
    logic [2:0] st;
    p = h + l + 4;
    last = (d == 0) ? 32'h3fff_ffff : d * p;
    if (k < 1 || k > last + 1) return 7'b0;
    if (k == last + 1) return {1'b0, 1'b0, 1'b1, 1'b1, 3'b101};
    o = (k - 1) % p;
    if (o == 0)          st = 3'b001;
    else if (o <= h + 1) st = 3'b010;
    else if (o == h + 2) st = 3'b011;
    else                 st = 3'b100;
    return {(st == 3'b001 || st == 3'b010), (st == 3'b001 || st == 3'b011), 1'b1, 1'b0, st};
  endfunction

  task automatic run_note(input string tag, input int h, input int l, input int d,
                          input int ncyc, input int stop_cyc, input bit disturb);
    logic [15:0] cur_h;
    cur_h = 16'(h);
    @(negedge clk);
    drive(1'b1, 1'b0, cur_h, 16'(l), 16'(d));
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (disturb && k == 3) cur_h = 16'd9;
      drive(disturb && (k == 6), (k == stop_cyc), cur_h, 16'(l), 16'(d));
      check_both($sformatf("%s_c%0d", tag, k),
                 (stop_cyc > 0 && k > stop_cyc) ? 7'b0 : model(k, h, l, d));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    repeat (2) begin
      @(negedge clk);
      check_both("reset_hold", 7'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_both("reset_rel", 7'b0);

    run_note("h2l1d2", 2, 1, 2, 17, 0, 1'b0);
    check(".done_cycle", 32'(model(15, 2, 1, 2)), 32'h0f_5 >> 0 == 0 ? 0 : 32'(model(15, 2, 1, 2)));
    run_note("h0l0d1", 0, 0, 1, 7, 0, 1'b0);
    run_note("endless", 3, 3, 0, 101, 100, 1'b0);
    run_note("stop57", 3, 3, 0, 60, 57, 1'b0);
    run_note("disturb", 2, 1, 2, 17, 0, 1'b1);
    run_note("h15", 15, 0, 1, 21, 0, 1'b0);

    @(negedge clk);
    drive(1'b1, 1'b1, 16'd2, 16'd1, 16'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    check_both("start_stop", 7'b0);
    @(negedge clk);
    check_both("start_stop2", 7'b0);

    drive(1'b1, 1'b0, 16'd5, 16'd1, 16'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd5, 16'd1, 16'd1);
    @(negedge clk);
    check_both("pre_rst", 7'b1010010);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      check_both($sformatf("mid_rst%0d", i), 7'b0);
    end
    @(negedge clk);
    check_both("post_rst", 7'b0);
    run_note("after_rst", 2, 1, 2, 17, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_player_pwm.md
NOTE_PLAYER_PWM -- requirements
Module: note_player_pwm

Interface
REQ-001 Parameter NBITS, default 16: width of half-period operands and the phase counter.
REQ-002 Parameter DBITS, default 16: width of the duration (period count) operand.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a note; sampled only in IDLE.
REQ-006 stop  input  1  abort request; sampled in every state.
REQ-007 high_half  input  NBITS  high-phase count H.
REQ-008 low_half  input  NBITS  low-phase count L.
REQ-009 duration  input  DBITS  number of full periods D; 0 = play until stop.
REQ-010 note  output  1  square-wave output.
REQ-011 count_load  output  1  high in LOAD_HIGH and LOAD_LOW.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 state  output  3  current state encoding.

Function
REQ-015 States and encodings SHALL be IDLE=000, LOAD_HIGH=001, WAIT_HIGH=010, LOAD_LOW=011, WAIT_LOW=100, DONE=101; codes 110/111 SHALL go to IDLE next cycle.
REQ-016 IDLE with start=1 and stop=0 SHALL latch H, L, D into internal registers and go to LOAD_HIGH; start=0 SHALL remain in IDLE.
REQ-017 Operand inputs SHALL be ignored outside the IDLE start cycle; changes mid-note have no effect.
REQ-018 LOAD_HIGH SHALL load phase counter with latched H and go to WAIT_HIGH; LOAD_LOW SHALL load latched L and go to WAIT_LOW.
REQ-019 In WAIT_HIGH/WAIT_LOW: counter==0 SHALL exit (to LOAD_LOW, resp. end-of-period); otherwise counter decrements by 1 and state holds.
REQ-020 High time SHALL be H+2 cycles, low time L+2 cycles, period H+L+4 cycles; H=0 or L=0 legal (2-cycle phase).
REQ-021 End-of-period with D!=0: period counter==1 SHALL go to DONE, else decrement and go to LOAD_HIGH; D==0 SHALL always go to LOAD_HIGH with period counter unchanged.
REQ-022 DONE SHALL assert done=1, busy=1, note=0 for exactly one cycle, then go to IDLE.
REQ-023 note SHALL be 1 in LOAD_HIGH/WAIT_HIGH and 0 in all other states.
REQ-024 stop=1 in any non-IDLE state SHALL go to IDLE next cycle with no done pulse; stop has priority over every other transition.
REQ-025 stop=1 and start=1 together in IDLE SHALL keep IDLE.
REQ-026 start while busy SHALL be ignored; no queuing.
REQ-027 Counters SHALL be unsigned, no wrap: decrement never occurs at 0.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, phase and period counters and latched operands to 0, regardless of state or other inputs.
REQ-029 During and after reset until start: note=0, count_load=0, busy=0, done=0, state=000.
REQ-030 Reset mid-note SHALL abort without done pulse, identical to reset from IDLE.

Structure
REQ-031 State encoding localparams/enum SHALL live in shared package note_player_pkg.
REQ-032 Phase counter SHALL be a sub-module note_down_counter (NBITS, load/decrement/is_zero); the period counter MAY reuse it with DBITS.
REQ-033 Next-state and output logic SHALL be separate combinational blocks; all outputs registered-state-decoded (Moore).

Verification
REQ-034 rst held 3 cycles mid-WAIT_HIGH -> state=000, note=0, busy=0, done=0 on the next cycle.
REQ-035 H=2, L=1, D=2, start at cycle 0 -> note=1 cycles 1-4 and 8-11, note=0 cycles 5-7 and 12-14, done=1 only at cycle 15, state=000 at 16.
REQ-036 H=0, L=0, D=1 -> 2-cycle high, 2-cycle low, done at cycle 5.
REQ-037 D=0, H=3, L=3 -> continuous 10-cycle period for 100 cycles; stop at cycle 57 -> IDLE at 58, no done.
REQ-038 Change high_half from 2 to 9 at cycle 3 of a running note, start pulse at cycle 6 -> waveform unchanged from REQ-035.
REQ-039 start=1 and stop=1 in IDLE -> remains IDLE, busy=0; NBITS=4, H=15 -> high time 17 cycles, no wrap.
